// File: rtl/switch_pkg.sv
// Shared sizes, header layout and helpers for the 3x3 switch fabric scheduler.
// No logic of its own; latency not applicable.
// Backpressure: not applicable (declarations only).
package switch_pkg;
  localparam int N_PORTS = 3;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 6;
  localparam int SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_IDLE = 2'd0;

  // Header byte: dest 0 discards the packet, 1..3 name an output port.
  typedef struct packed {
    logic [1:0]       dest;
    logic [LEN_W-1:0] len;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } in_state_e;

  // Round-robin pointer to use after the one-hot owner releases: the input after it.
  function automatic logic [1:0] rr_next(input logic [N_PORTS-1:0] oh);
    return oh[0] ? 2'd1 : (oh[1] ? 2'd2 : 2'd0);
  endfunction

  // Mux select code for a one-hot owner: input k (numbered from 1), or the idle word.
  function automatic logic [SEL_W-1:0] sel_code(input logic [N_PORTS-1:0] oh);
    return oh[0] ? 2'd1 : (oh[1] ? 2'd2 : (oh[2] ? 2'd3 : SEL_IDLE));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester per output, scanning from ptr with wrap.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; a zero request vector yields a zero grant.
module rr_arbiter
  import switch_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [1:0]         ptr,
  output logic [N_PORTS-1:0] gnt
);
  logic [2:0] idx;
  logic       found;

  // Walk ptr, ptr+1, ptr+2 (mod N_PORTS); the first active request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(N_PORTS)) idx = idx - 3'(N_PORTS);
      if (!found && req[idx[1:0]]) begin
        gnt[idx[1:0]] = 1'b1;
        found         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/crossbar_scheduler.sv
// Packet scheduler for the 3x3 fabric: grants outputs to inputs per packet, drives FIFO pops and mux selects.
// Latency: header seen cycle t -> grant at end of t -> rdreq t+1 -> out_valid/sop t+2.
// Backpressure: an empty FIFO mid-packet stalls that transfer (no timeout); enable=0 blocks new grants only.
module crossbar_scheduler
  import switch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [N_PORTS-1:0]        empty,
  input  logic [N_PORTS*DATA_W-1:0] head,
  output logic [N_PORTS-1:0]        rdreq,
  output logic [N_PORTS*SEL_W-1:0]  sel,
  output logic [N_PORTS-1:0]        out_valid,
  output logic [N_PORTS-1:0]        out_sop,
  output logic [N_PORTS-1:0]        out_eop,
  output logic [N_PORTS-1:0]        busy,
  output logic [7:0]                drop_cnt
);
  localparam int CNT_W = LEN_W + 1;

  in_state_e          state  [N_PORTS];
  logic [CNT_W-1:0]   count  [N_PORTS];
  logic [N_PORTS-1:0] first;
  logic [N_PORTS-1:0] owned;
  logic [N_PORTS-1:0] owner  [N_PORTS];  // one-hot input currently owning each output
  logic [1:0]         rr_ptr [N_PORTS];

  hdr_t               hdr    [N_PORTS];
  logic [N_PORTS-1:0] req    [N_PORTS];
  logic [N_PORTS-1:0] gnt    [N_PORTS];
  logic [N_PORTS-1:0] granted;
  logic [N_PORTS-1:0] drop_go;
  logic [N_PORTS-1:0] last_pop;
  logic [N_PORTS-1:0] out_pop;
  logic [N_PORTS-1:0] out_first;
  logic [N_PORTS-1:0] out_last;
  logic [7:0]         n_drop;

  // View each FIFO head as a header.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) hdr[i] = hdr_t'(head[i*DATA_W +: DATA_W]);
  end

  // Idle inputs with a visible header either request their output or head for discard; busy inputs pop.
  always_comb begin
    drop_go  = '0;
    rdreq    = '0;
    last_pop = '0;
    for (int o = 0; o < N_PORTS; o++) req[o] = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      drop_go[i]  = enable && (state[i] == IDLE) && !empty[i] && (hdr[i].dest == 2'd0);
      rdreq[i]    = (state[i] != IDLE) && !empty[i];
      last_pop[i] = rdreq[i] && (count[i] == CNT_W'(1));
      for (int o = 0; o < N_PORTS; o++)
        req[o][i] = enable && !owned[o] && (state[i] == IDLE) && !empty[i] &&
                    (hdr[i].dest == 2'(o + 1));
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req (req[o]),
      .ptr (rr_ptr[o]),
      .gnt (gnt[o])
    );
  end

  // Fold arbiter results per input, and map each output's owner onto its pops.
  always_comb begin
    granted   = '0;
    out_pop   = '0;
    out_first = '0;
    out_last  = '0;
    n_drop    = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      granted      = granted | gnt[o];
      out_pop[o]   = |(owner[o] & rdreq);
      out_first[o] = |(owner[o] & rdreq & first);
      out_last[o]  = |(owner[o] & last_pop);
    end
    for (int i = 0; i < N_PORTS; i++) n_drop = n_drop + 8'(drop_go[i]);
  end

  // Per-input packet FSM: load L+1 on entry, count pops down, back to IDLE on the last byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) begin
        state[i] <= IDLE;
        count[i] <= '0;
      end
      first <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        case (state[i])
          IDLE: begin
            if (drop_go[i] || granted[i]) begin
              state[i] <= drop_go[i] ? DROP : XFER;
              count[i] <= {1'b0, hdr[i].len} + CNT_W'(1);
              first[i] <= 1'b1;
            end
          end
          default: begin
            if (rdreq[i]) begin
              count[i] <= count[i] - CNT_W'(1);
              first[i] <= 1'b0;
              if (last_pop[i]) state[i] <= IDLE;
            end
          end
        endcase
      end
    end
  end

  // Output ownership: claim on grant; release and rotate the pointer past the owner on its last pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owned    <= '0;
      drop_cnt <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= 2'd0;
      end
    end else begin
      drop_cnt <= drop_cnt + n_drop;
      for (int o = 0; o < N_PORTS; o++) begin
        if (|gnt[o]) begin
          owned[o] <= 1'b1;
          owner[o] <= gnt[o];
        end else if (out_last[o]) begin
          owned[o]  <= 1'b0;
          owner[o]  <= '0;
          rr_ptr[o] <= rr_next(owner[o]);
        end
      end
    end
  end

  // Mux-side outputs trail the pop by one register so they line up with the registered FIFO data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
      out_sop   <= '0;
      out_eop   <= '0;
      sel       <= '0;
    end else begin
      out_valid <= out_pop;
      out_sop   <= out_first;
      out_eop   <= out_last;
      for (int o = 0; o < N_PORTS; o++)
        sel[o*SEL_W +: SEL_W] <= out_pop[o] ? sel_code(owner[o]) : SEL_IDLE;
    end
  end

  assign busy = owned;
endmodule

// File: tb/tb_crossbar_scheduler.sv
// Bench for crossbar_scheduler: FIFO and registered-mux model, packet scoreboard, directed and random traffic.
// Latency expectations come from the header/grant/pop timing rules of the block.
// Backpressure is exercised by hiding FIFO heads (hold) and by dropping enable.
module tb_crossbar_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  empty;
  logic [23:0] head;
  logic [2:0]  rdreq;
  logic [5:0]  sel;
  logic [2:0]  out_valid;
  logic [2:0]  out_sop;
  logic [2:0]  out_eop;
  logic [2:0]  busy;
  logic [7:0]  drop_cnt;

  crossbar_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .empty     (empty),
    .head      (head),
    .rdreq     (rdreq),
    .sel       (sel),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int o;
    int s;
    bit sop;
    bit eop;
  } ev_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] fq    [3][$];   // FIFO contents (show-ahead)
  logic [7:0] exp_q [3][$];   // bytes each input must still deliver to some output
  int         rem [3];        // payload bytes left in current packet per output, -1 = expect header
  logic [7:0] last_pop [3];   // registered mux input: byte popped last cycle
  logic [2:0] last_rd;
  logic [2:0] hold;
  int         drops_exp;
  int         rd_cnt [3];
  ev_t        evq [$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      empty[i]       = hold[i] || (fq[i].size() == 0);
      head[i*8 +: 8] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic monitor();
    int         s;
    int         src;
    int         used;
    logic [7:0] b;
    ev_t        e;
    used = 0;
    for (int o = 0; o < 3; o++) begin
      s = int'(sel[o*2 +: 2]);
      chk("valid_vs_sel", int'(out_valid[o]), int'(s != 0));
      if (out_valid[o] && s >= 1 && s <= 3) begin
        src = s - 1;
        chk("dup_sel", (used >> src) & 1, 0);
        used = used | (1 << src);
        chk("src_popped", int'(last_rd[src]), 1);
        b = last_pop[src];
        e.cyc = cyc; e.o = o; e.s = s; e.sop = out_sop[o]; e.eop = out_eop[o];
        evq.push_back(e);
        if (rem[o] < 0) begin
          chk("sop", int'(out_sop[o]), 1);
          chk("dest", int'(b[7:6]), o + 1);
          rem[o] = int'(b[5:0]);
        end else begin
          chk("sop", int'(out_sop[o]), 0);
          rem[o]--;
        end
        if (exp_q[src].size() == 0) chk("extra_byte", int'(b), -1);
        else chk("byte", int'(b), int'(exp_q[src].pop_front()));
        chk("eop", int'(out_eop[o]), int'(rem[o] == 0));
        if (rem[o] == 0) rem[o] = -1;
      end else begin
        chk("flags_idle", int'({out_sop[o], out_eop[o]}), 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = rdreq[i];
      if (rdreq[i]) begin
        chk("rd_when_empty", int'(empty[i]), 0);
        rd_cnt[i]++;
        if (!empty[i]) last_pop[i] = fq[i].pop_front();
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() != 0 || busy != 3'b0 || out_valid != 3'b0)
           && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", int'(n < budget), 1);
    tick();
    tick();
  endtask

  task automatic push_pkt(input int i, input logic [7:0] h);
    logic [7:0] b;
    fq[i].push_back(h);
    if (h[7:6] != 2'd0) exp_q[i].push_back(h);
    else drops_exp++;
    for (int k = 0; k < int'(h[5:0]); k++) begin
      b = 8'($urandom);
      fq[i].push_back(b);
      if (h[7:6] != 2'd0) exp_q[i].push_back(b);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_rdreq", int'(rdreq), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sop", int'(out_sop), 0);
    chk("rst_eop", int'(out_eop), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      fq[i].delete();
      exp_q[i].delete();
      rem[i] = -1;
    end
    last_rd   = '0;
    hold      = '0;
    drops_exp = 0;
    evq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r0;
    int d0;
    int t4_sel [3];
    logic [7:0] h;
    t4_sel = '{2, 3, 1};
    reset_n = 1'b0; enable = 1'b1; empty = '1; head = '0; hold = '0; last_rd = '0;
    drops_exp = 0;
    for (int i = 0; i < 3; i++) begin rem[i] = -1; rd_cnt[i] = 0; last_pop[i] = '0; end
    #1;
    apply_reset();

    // Single packet in1 -> out2, L=3
    r0 = rd_cnt[0];
    push_pkt(0, 8'h83);
    t0 = cyc;
    run_until_idle(100);
    chk("t2_bytes", evq.size(), 4);
    if (evq.size() == 4) begin
      chk("t2_first_lat", evq[0].cyc - t0, 2);
      chk("t2_last_lat", evq[3].cyc - t0, 5);
      chk("t2_out", evq[0].o, 1);
      chk("t2_sel", evq[0].s, 1);
      chk("t2_sop", int'(evq[0].sop), 1);
      chk("t2_eop", int'(evq[3].eop), 1);
    end
    chk("t2_rdreq", rd_cnt[0] - r0, 4);

    // Contention on out1: in1 first (pointer at input 1), one idle cycle, then in3
    evq.delete();
    push_pkt(0, 8'h41);
    push_pkt(2, 8'h41);
    t0 = cyc;
    run_until_idle(100);
    chk("t3_bytes", evq.size(), 4);
    if (evq.size() == 4) begin
      chk("t3_first_sel", evq[0].s, 1);
      chk("t3_first_lat", evq[0].cyc - t0, 2);
      chk("t3_second_sel", evq[2].s, 3);
      chk("t3_second_lat", evq[2].cyc - t0, 5);
    end
    // in2 alone moves the out1 pointer to input 3; the next in1/in3 pair serves in3 first
    evq.delete();
    push_pkt(1, 8'h41);
    run_until_idle(100);
    evq.delete();
    push_pkt(0, 8'h41);
    push_pkt(2, 8'h41);
    run_until_idle(100);
    chk("t3_rot_bytes", evq.size(), 4);
    if (evq.size() == 4) begin
      chk("t3_rot_first", evq[0].s, 3);
      chk("t3_rot_second", evq[2].s, 1);
    end

    // Parallel: in1->out3, in2->out1, in3->out2 granted on the same edge
    evq.delete();
    push_pkt(0, 8'hC2);
    push_pkt(1, 8'h42);
    push_pkt(2, 8'h82);
    t0 = cyc;
    tick();
    chk("t4_busy", int'(busy), 7);
    run_until_idle(100);
    chk("t4_bytes", evq.size(), 9);
    for (int k = 0; k < evq.size(); k++) begin
      if (evq[k].sop) begin
        chk("t4_start", evq[k].cyc - t0, 2);
        chk("t4_sel", evq[k].s, t4_sel[evq[k].o]);
      end
    end

    // Stall: in2 L=4, FIFO empty for 3 cycles after 2 bytes
    evq.delete();
    push_pkt(1, 8'h44);
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      hold[1] = (cyc - t0 >= 3) && (cyc - t0 <= 5);
      tick();
    end
    hold = '0;
    run_until_idle(100);
    chk("t5_bytes", evq.size(), 5);
    if (evq.size() == 5) begin
      chk("t5_first_lat", evq[0].cyc - t0, 2);
      chk("t5_gap", evq[2].cyc - evq[1].cyc, 4);
      chk("t5_eop5", int'(evq[4].eop), 1);
    end
    // L=0: single byte carries both sop and eop
    evq.delete();
    push_pkt(1, 8'h40);
    run_until_idle(100);
    chk("t5_l0_bytes", evq.size(), 1);
    if (evq.size() == 1) begin
      chk("t5_l0_sop", int'(evq[0].sop), 1);
      chk("t5_l0_eop", int'(evq[0].eop), 1);
    end

    // Discard: dest 0, L=2 -> 3 pops, nothing out, drop_cnt +1
    evq.delete();
    r0 = rd_cnt[0];
    d0 = int'(drop_cnt);
    chk("t6_cnt_before", d0, drops_exp);
    push_pkt(0, 8'h02);
    run_until_idle(100);
    chk("t6_pops", rd_cnt[0] - r0, 3);
    chk("t6_no_out", evq.size(), 0);
    chk("t6_drop_inc", int'(drop_cnt) - d0, 1);
    // enable low: pending header waits, then goes once enable returns
    enable = 1'b0;
    r0 = rd_cnt[2];
    push_pkt(2, 8'h81);
    for (int k = 0; k < 6; k++) tick();
    chk("t6_hold_rd", rd_cnt[2] - r0, 0);
    chk("t6_hold_busy", int'(busy), 0);
    enable = 1'b1;
    t0 = cyc;
    run_until_idle(100);
    chk("t6_resume_bytes", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("t6_resume_lat", evq[0].cyc - t0, 2);
      chk("t6_resume_out", evq[0].o, 1);
    end

    // Random traffic, stalls and enable toggling against the packet scoreboard
    evq.delete();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = int'($urandom_range(0, 2));
        if (fq[i].size() < 40) begin
          h[7:6] = 2'($urandom_range(0, 3));
          h[5:0] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
          push_pkt(i, h);
        end
      end
      hold   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b0;
      enable = ($urandom_range(0, 15) != 0);
      tick();
      if (evq.size() > 64) evq.delete();
    end
    enable = 1'b1;
    hold   = '0;
    run_until_idle(5000);
    for (int i = 0; i < 3; i++) chk("rand_leftover", exp_q[i].size(), 0);
    chk("rand_drop_cnt", int'(drop_cnt), drops_exp % 256);

    // Reset mid-packet: in1 L=5 after header pop (5 bytes still to go)
    push_pkt(0, 8'h85);
    tick();
    tick();
    chk("t1_busy_before", int'(busy), 2);
    apply_reset();
    push_pkt(1, 8'h41);
    run_until_idle(100);
    chk("t1_recover_bytes", evq.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
